hydra_pkt_gen: RTL and testbench
================================

// Module: hydra_pkt_gen
// PURPOSE
//  Synthesizable multi-channel packet source for the hydra switch write side; replaces hand-scripted stimulus.
//  Each channel drives one switch input port (sop/vld/eop/data), honours per-port pause, and emits configured
//  packets: header word then LEN payload words. Used in FPGA self-test and as a reusable bench stimulus engine.
// PARAMETERS
//  NUM_CH    4   channels = switch input ports driven
//  DATA_W    16  data word width (>= LEN_W+PRIO_W+DEST_W)
//  DEST_W    2   destination field width (log2 of switch output ports)
//  PRIO_W    2   priority field width
//  LEN_W     8   payload-length field width
//  GAP_W     8   inter-packet idle-gap counter width
//  NUM_W     16  packets-per-run counter width
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               synchronous reset, active low
//  cfg_we     in   1               write config of channel cfg_ch
//  cfg_ch     in   $clog2(NUM_CH)  target channel
//  cfg_dest   in   DEST_W          header destination
//  cfg_prio   in   PRIO_W          header priority
//  cfg_len    in   LEN_W           payload words per packet
//  cfg_gap    in   GAP_W           idle cycles between eop and next sop
//  cfg_num    in   NUM_W           packets per run; 0 = run until stop
//  start      in   NUM_CH          per-channel start pulse
//  stop       in   NUM_CH          per-channel stop request (finishes current packet)
//  pause      in   NUM_CH          switch backpressure
//  wr_sop     out  NUM_CH          start-of-packet pulse
//  wr_vld     out  NUM_CH          data valid
//  wr_eop     out  NUM_CH          end-of-packet pulse
//  wr_data    out  NUM_CH*DATA_W   packed per-channel data
//  busy       out  NUM_CH          channel running
//  done       out  NUM_CH          one-cycle pulse when a run ends
//  pkt_cnt    out  NUM_CH*NUM_W    packets completed in current/last run
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output and all channel state; config regs reset to 0.
//  - Channel FSM: IDLE -> SOP -> HDR -> PAY -> EOP -> GAP -> SOP ... ; GAP/EOP -> IDLE when run ends.
//  - Wire format per packet: 1 cycle wr_sop (vld=0); 1+LEN cycles wr_vld; 1 cycle wr_eop (vld=0).
//  - Header word: [DEST_W-1:0]=dest, next PRIO_W bits=prio, next LEN_W bits=len, upper bits 0.
//  - Payload word k (k=0..LEN-1) = {seq[7:0], k[7:0]} zero-extended/truncated to DATA_W; seq = packet index in run.
//  - cfg_len=0: header-only packet (sop, 1 vld header beat, eop).
//  - start[i] in IDLE at edge t -> wr_sop[i] high in cycle t+1. start while busy ignored.
//  - Config is snapshotted at every SOP entry; cfg write to a busy channel affects the next packet only.
//    cfg_we and start same cycle/channel: new config is used.
//  - pause[i] sampled each edge: while high, no sop or vld beat is issued next cycle; current word and index held,
//    no beat lost or repeated. wr_eop is not gated by pause. GAP counter runs regardless of pause.
//  - cfg_gap=0: sop follows eop in the next cycle.
//  - Run ends after cfg_num packets (eop of last) or, with stop seen, after current packet's eop; stop in IDLE
//    or in GAP ends immediately. done pulses the cycle busy falls. pkt_cnt cleared at start, increments at each eop.
//  - Counters wrap silently at width limit; cfg_num=0 never ends except by stop.
//  - rst_n low mid-packet: outputs 0 next cycle; packet truncated (switch must tolerate; bench asserts rst).
// CONFIGURATION
//  HYDRA_GEN_LFSR_EN defined: payload word = per-channel 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), seed
//    16'h1 + channel index at start, advanced once per payload beat issued, replicated/truncated to DATA_W.
//  Undefined: counting payload as above; no LFSR logic synthesized.
// STRUCTURE
//  Package hydra_gen_pkg: gen_state_t enum (IDLE,SOP,HDR,PAY,EOP,GAP), header field offset functions,
//    LFSR taps/seed constants.
//  Sub-module hydra_gen_chan: one channel FSM + counters + config snapshot; top is config demux, NUM_CH
//    generate instances and output packing.
// TESTING
//  1 cfg ch0 dest=3 prio=1 len=31 gap=0 num=1, start[0] -> sop, header 16'h01F7, payloads 16'h0000..16'h001E,
//    eop, done[0] one cycle after eop, pkt_cnt[0]=1.
//  2 ch1 len=4 num=3 gap=2 -> 3 packets, exactly 2 idle cycles between each eop and sop, seq byte 0,1,2.
//  3 ch0 len=8, pause[0] high 3 cycles at beat 2 -> stream has no vld for 3 cycles, beats 0..7 in order, none lost.
//  4 all 4 channels start same cycle, len=0 num=0, stop after 5 cycles -> each header-only packet, clean stop at eop.
//  5 rst_n low mid-payload on ch2 -> all outputs 0 next cycle; busy=0; restart yields seq 0.
//  6 HYDRA_GEN_LFSR_EN: ch0 len=3 -> payloads 16'h0001 then two successive LFSR states vs reference model.

Source files
------------

// File: rtl/hydra_gen_pkg.sv
// Shared types and helpers for the hydra packet generator: channel state encoding,
// header field offsets and the payload LFSR constants.
package hydra_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SOP,
    HDR,
    PAY,
    EOP,
    GAP
  } gen_state_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h0001;

  function automatic int hdr_prio_lsb(input int dest_w);
    return dest_w;
  endfunction

  function automatic int hdr_len_lsb(input int dest_w, input int prio_w);
    return dest_w + prio_w;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/hydra_gen_chan.sv
// One packet-generator channel: FSM, counters, config registers and per-packet snapshot.
// HYDRA_GEN_LFSR_EN selects LFSR payload words instead of {seq, index} counting words.
module hydra_gen_chan
  import hydra_gen_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEST_W = 2,
  parameter int PRIO_W = 2,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 8,
  parameter int NUM_W  = 16
`ifdef HYDRA_GEN_LFSR_EN
  ,
  parameter int CH_IDX = 0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [DEST_W-1:0] cfg_dest,
  input  logic [PRIO_W-1:0] cfg_prio,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [NUM_W-1:0]  cfg_num,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic              wr_sop,
  output logic              wr_vld,
  output logic              wr_eop,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [NUM_W-1:0]  pkt_cnt
);

  localparam int PRIO_LSB = hdr_prio_lsb(DEST_W);
  localparam int LEN_LSB  = hdr_len_lsb(DEST_W, PRIO_W);

  gen_state_t        state_q, state_nxt;
  logic              beat_q, beat_nxt;
  logic [LEN_W-1:0]  idx_q, idx_nxt;
  logic [GAP_W-1:0]  gap_q, gap_nxt;
  logic [NUM_W-1:0]  cnt_nxt;
  logic              stop_q, stop_nxt;
  logic              snap, done_nxt;

  logic [DEST_W-1:0] cfg_dest_q, cur_dest, eff_dest;
  logic [PRIO_W-1:0] cfg_prio_q, cur_prio, eff_prio;
  logic [LEN_W-1:0]  cfg_len_q, cur_len, eff_len;
  logic [GAP_W-1:0]  cfg_gap_q, cur_gap, eff_gap;
  logic [NUM_W-1:0]  cfg_num_q, cur_num, eff_num;

  logic [DATA_W-1:0] hdr_word, pay_word, data_nxt;

  // A write landing on the snapshot edge must win over the stored copy
  assign eff_dest = cfg_we ? cfg_dest : cfg_dest_q;
  assign eff_prio = cfg_we ? cfg_prio : cfg_prio_q;
  assign eff_len  = cfg_we ? cfg_len  : cfg_len_q;
  assign eff_gap  = cfg_we ? cfg_gap  : cfg_gap_q;
  assign eff_num  = cfg_we ? cfg_num  : cfg_num_q;

  // beat_q means the current state's sop/vld beat is on the wire this cycle;
  // a state only advances once its beat went out, so pause never drops a word.
  always_comb begin
    state_nxt = state_q;
    beat_nxt  = !pause;
    idx_nxt   = idx_q;
    gap_nxt   = gap_q;
    cnt_nxt   = pkt_cnt;
    stop_nxt  = stop_q | stop;
    snap      = 1'b0;
    done_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        stop_nxt = 1'b0;
        if (start && !stop) begin
          state_nxt = SOP;
          snap      = 1'b1;
          cnt_nxt   = '0;
        end
      end
      SOP: if (beat_q) state_nxt = HDR;
      HDR: if (beat_q) begin
        if (cur_len == '0) begin
          state_nxt = EOP;
          beat_nxt  = 1'b1;
        end else begin
          state_nxt = PAY;
          idx_nxt   = '0;
        end
      end
      PAY: if (beat_q) begin
        if (idx_q == cur_len - LEN_W'(1)) begin
          state_nxt = EOP;
          beat_nxt  = 1'b1;
        end else begin
          idx_nxt = idx_q + LEN_W'(1);
        end
      end
      EOP: begin
        cnt_nxt = pkt_cnt + NUM_W'(1);
        if (((cur_num != '0) && (cnt_nxt == cur_num)) || stop_nxt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (cur_gap == '0) begin
          state_nxt = SOP;
          snap      = 1'b1;
        end else begin
          state_nxt = GAP;
          gap_nxt   = cur_gap;
        end
      end
      GAP: begin
        if (stop_nxt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (gap_q == GAP_W'(1)) begin
          state_nxt = SOP;
          snap      = 1'b1;
        end else begin
          gap_nxt = gap_q - GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef HYDRA_GEN_LFSR_EN
  logic [15:0] lfsr_q, lfsr_cur;
  logic        pay_adv, run_start;

  assign pay_adv   = (state_q == PAY) && beat_q;
  assign run_start = (state_q == IDLE) && (state_nxt == SOP);
  assign lfsr_cur  = pay_adv ? lfsr_next(lfsr_q) : lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n)         lfsr_q <= '0;
    else if (run_start) lfsr_q <= LFSR_SEED + 16'(CH_IDX);
    else if (pay_adv)   lfsr_q <= lfsr_next(lfsr_q);
  end

  always_comb begin
    pay_word = '0;
    for (int b = 0; b < DATA_W; b++) pay_word[b] = lfsr_cur[b % 16];
  end
`else
  assign pay_word = DATA_W'({8'(pkt_cnt), 8'(idx_nxt)});
`endif

  always_comb begin
    hdr_word                       = '0;
    hdr_word[DEST_W-1:0]           = cur_dest;
    hdr_word[PRIO_LSB +: PRIO_W]   = cur_prio;
    hdr_word[LEN_LSB +: LEN_W]     = cur_len;
    data_nxt = '0;
    if ((state_nxt == HDR) && beat_nxt)      data_nxt = hdr_word;
    else if ((state_nxt == PAY) && beat_nxt) data_nxt = pay_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= 1'b0;
      idx_q      <= '0;
      gap_q      <= '0;
      stop_q     <= 1'b0;
      pkt_cnt    <= '0;
      cfg_dest_q <= '0;
      cfg_prio_q <= '0;
      cfg_len_q  <= '0;
      cfg_gap_q  <= '0;
      cfg_num_q  <= '0;
      cur_dest   <= '0;
      cur_prio   <= '0;
      cur_len    <= '0;
      cur_gap    <= '0;
      cur_num    <= '0;
      wr_sop     <= 1'b0;
      wr_vld     <= 1'b0;
      wr_eop     <= 1'b0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_nxt;
      beat_q  <= beat_nxt;
      idx_q   <= idx_nxt;
      gap_q   <= gap_nxt;
      stop_q  <= stop_nxt;
      pkt_cnt <= cnt_nxt;
      if (cfg_we) begin
        cfg_dest_q <= cfg_dest;
        cfg_prio_q <= cfg_prio;
        cfg_len_q  <= cfg_len;
        cfg_gap_q  <= cfg_gap;
        cfg_num_q  <= cfg_num;
      end
      if (snap) begin
        cur_dest <= eff_dest;
        cur_prio <= eff_prio;
        cur_len  <= eff_len;
        cur_gap  <= eff_gap;
        cur_num  <= eff_num;
      end
      wr_sop  <= (state_nxt == SOP) && beat_nxt;
      wr_vld  <= ((state_nxt == HDR) || (state_nxt == PAY)) && beat_nxt;
      wr_eop  <= (state_nxt == EOP);
      wr_data <= data_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
    end
  end

endmodule

// File: rtl/hydra_pkt_gen.sv
// Multi-channel packet source for the hydra switch write side: config demux plus one
// hydra_gen_chan per port. HYDRA_GEN_LFSR_EN switches payloads to per-channel LFSR words.
module hydra_pkt_gen
  import hydra_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int DEST_W = 2,
  parameter int PRIO_W = 2,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 8,
  parameter int NUM_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [DEST_W-1:0]        cfg_dest,
  input  logic [PRIO_W-1:0]        cfg_prio,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [GAP_W-1:0]         cfg_gap,
  input  logic [NUM_W-1:0]         cfg_num,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        stop,
  input  logic [NUM_CH-1:0]        pause,
  output logic [NUM_CH-1:0]        wr_sop,
  output logic [NUM_CH-1:0]        wr_vld,
  output logic [NUM_CH-1:0]        wr_eop,
  output logic [NUM_CH*DATA_W-1:0] wr_data,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH*NUM_W-1:0]  pkt_cnt
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

    hydra_gen_chan #(
      .DATA_W (DATA_W),
      .DEST_W (DEST_W),
      .PRIO_W (PRIO_W),
      .LEN_W  (LEN_W),
      .GAP_W  (GAP_W),
      .NUM_W  (NUM_W)
`ifdef HYDRA_GEN_LFSR_EN
      ,
      .CH_IDX (i)
`endif
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (ch_we),
      .cfg_dest (cfg_dest),
      .cfg_prio (cfg_prio),
      .cfg_len  (cfg_len),
      .cfg_gap  (cfg_gap),
      .cfg_num  (cfg_num),
      .start    (start[i]),
      .stop     (stop[i]),
      .pause    (pause[i]),
      .wr_sop   (wr_sop[i]),
      .wr_vld   (wr_vld[i]),
      .wr_eop   (wr_eop[i]),
      .wr_data  (wr_data[i*DATA_W +: DATA_W]),
      .busy     (busy[i]),
      .done     (done[i]),
      .pkt_cnt  (pkt_cnt[i*NUM_W +: NUM_W])
    );
  end

endmodule

// File: tb/tb_hydra_pkt_gen.sv
// Directed self-checking bench for hydra_pkt_gen (4 channels, 16-bit data).
module tb_hydra_pkt_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_dest = '0;
  logic [1:0]  cfg_prio = '0;
  logic [7:0]  cfg_len = '0;
  logic [7:0]  cfg_gap = '0;
  logic [15:0] cfg_num = '0;
  logic [3:0]  start = '0;
  logic [3:0]  stop = '0;
  logic [3:0]  pause = '0;
  logic [3:0]  wr_sop, wr_vld, wr_eop, busy, done;
  logic [63:0] wr_data;
  logic [63:0] pkt_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hydra_pkt_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_dest(cfg_dest),
    .cfg_prio(cfg_prio), .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_num(cfg_num),
    .start(start), .stop(stop), .pause(pause), .wr_sop(wr_sop), .wr_vld(wr_vld),
    .wr_eop(wr_eop), .wr_data(wr_data), .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Captured stream of one channel
  int          sop_at[$];
  int          eop_at[$];
  int          beat_at[$];
  logic [15:0] beat_v[$];
  bit          cap_done;
  int          cap_done_at;
  logic [15:0] cap_cnt;
  logic        cap_busy;

  function automatic logic [15:0] exp_pay(input int ch, input int seq, input int k, input int beat);
`ifdef HYDRA_GEN_LFSR_EN
    logic [15:0] s;
    s = 16'h0001 + 16'(ch);
    for (int i = 0; i < beat; i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s;
`else
    return {8'(seq), 8'(k)} | 16'(beat & 0);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int dest, input int prio, input int len,
                     input int gap, input int num);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_dest = 2'(dest); cfg_prio = 2'(prio);
    cfg_len = 8'(len); cfg_gap = 8'(gap); cfg_num = 16'(num);
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic capture(input int ch, input int max_cyc, input int pause_after, input int pause_cyc);
    int npause;
    int nvld;
    npause = 0; nvld = 0;
    sop_at.delete(); eop_at.delete(); beat_at.delete(); beat_v.delete();
    cap_done = 0; cap_done_at = -1; cap_cnt = '0; cap_busy = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (wr_sop[ch]) sop_at.push_back(c);
      if (wr_eop[ch]) eop_at.push_back(c);
      if (wr_vld[ch]) begin
        beat_v.push_back(wr_data[ch*16 +: 16]);
        beat_at.push_back(c);
        nvld++;
        if (nvld == pause_after) npause = pause_cyc;
      end
      if (done[ch]) begin
        cap_done = 1; cap_done_at = c;
        cap_cnt = pkt_cnt[ch*16 +: 16]; cap_busy = busy[ch];
        break;
      end
      pause[ch] = (npause > 0);
      if (npause > 0) npause--;
      tick;
    end
    pause = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    n_checks++; if ({wr_sop, wr_vld, wr_eop} !== 12'h0) $display("FAIL reset_ctl: got %h want 000", {wr_sop, wr_vld, wr_eop}); else n_pass++;
    n_checks++; if (wr_data !== 64'h0) $display("FAIL reset_data: got %h want 0", wr_data); else n_pass++;
    n_checks++; if ({busy, done} !== 8'h0) $display("FAIL reset_busy_done: got %h want 00", {busy, done}); else n_pass++;
    n_checks++; if (pkt_cnt !== 64'h0) $display("FAIL reset_pkt_cnt: got %h want 0", pkt_cnt); else n_pass++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    logic [15:0] e;
    cfg(0, 3, 1, 31, 0, 1);
    start[0] = 1'b1; tick; start = '0;
    capture(0, 80, 0, 0);
    n_checks++; if (!cap_done) $display("FAIL t1_done: run did not end within bound"); else n_pass++;
    n_checks++; if (sop_at.size() != 1 || sop_at[0] != 0) $display("FAIL t1_sop: got %0d sops want 1 at cycle 0", sop_at.size()); else n_pass++;
    n_checks++;
    if (beat_v.size() != 32) $display("FAIL t1_beats: got %0d beats want 32", beat_v.size());
    else begin
      n_pass++;
      for (int i = 0; i < 32; i++) begin
        e = (i == 0) ? 16'h01F7 : exp_pay(0, 0, i - 1, i - 1);
        n_checks++; if (beat_v[i] !== e) $display("FAIL t1_beat%0d: got %h want %h", i, beat_v[i], e); else n_pass++;
      end
    end
    n_checks++; if (eop_at.size() != 1 || eop_at[0] != 33) $display("FAIL t1_eop: got %0d eops want 1 at cycle 33", eop_at.size()); else n_pass++;
    n_checks++; if (cap_done_at != 34) $display("FAIL t1_done_at: got %0d want 34", cap_done_at); else n_pass++;
    n_checks++; if (cap_busy !== 1'b0) $display("FAIL t1_busy: got %b want 0", cap_busy); else n_pass++;
    n_checks++; if (cap_cnt !== 16'd1) $display("FAIL t1_pkt_cnt: got %0d want 1", cap_cnt); else n_pass++;
    tick;
    n_checks++; if (done[0] !== 1'b0) $display("FAIL t1_done_pulse: got %b want 0", done[0]); else n_pass++;
  endtask

  task automatic test_gap;
    logic [15:0] e;
    cfg(1, 1, 2, 4, 2, 3);
    start[1] = 1'b1; tick; start = '0;
    capture(1, 80, 0, 0);
    n_checks++; if (!cap_done || cap_done_at != 25) $display("FAIL t2_done_at: got %0d want 25", cap_done_at); else n_pass++;
    n_checks++;
    if (sop_at.size() != 3 || eop_at.size() != 3) $display("FAIL t2_count: got %0d/%0d sop/eop want 3/3", sop_at.size(), eop_at.size());
    else begin
      n_pass++;
      for (int p = 0; p < 3; p++) begin
        n_checks++; if (sop_at[p] != 9 * p) $display("FAIL t2_sop%0d: got %0d want %0d", p, sop_at[p], 9 * p); else n_pass++;
        n_checks++; if (eop_at[p] != 9 * p + 6) $display("FAIL t2_eop%0d: got %0d want %0d", p, eop_at[p], 9 * p + 6); else n_pass++;
      end
    end
    n_checks++;
    if (beat_v.size() != 15) $display("FAIL t2_beats: got %0d want 15", beat_v.size());
    else begin
      n_pass++;
      for (int i = 0; i < 15; i++) begin
        e = (i % 5 == 0) ? 16'h0049 : exp_pay(1, i / 5, i % 5 - 1, (i / 5) * 4 + i % 5 - 1);
        n_checks++; if (beat_v[i] !== e) $display("FAIL t2_beat%0d: got %h want %h", i, beat_v[i], e); else n_pass++;
      end
    end
    n_checks++; if (cap_cnt !== 16'd3) $display("FAIL t2_pkt_cnt: got %0d want 3", cap_cnt); else n_pass++;
  endtask

  task automatic test_pause;
    logic [15:0] e;
    cfg(0, 2, 3, 8, 0, 1);
    start[0] = 1'b1; tick; start = '0;
    capture(0, 80, 3, 3);
    n_checks++;
    if (beat_v.size() != 9) $display("FAIL t3_beats: got %0d want 9", beat_v.size());
    else begin
      n_pass++;
      for (int i = 0; i < 9; i++) begin
        e = (i == 0) ? 16'h008E : exp_pay(0, 0, i - 1, i - 1);
        n_checks++; if (beat_v[i] !== e) $display("FAIL t3_beat%0d: got %h want %h", i, beat_v[i], e); else n_pass++;
      end
      n_checks++; if (beat_at[3] - beat_at[2] != 4) $display("FAIL t3_stall: got gap %0d want 4", beat_at[3] - beat_at[2]); else n_pass++;
      n_checks++; if (beat_at[2] - beat_at[1] != 1) $display("FAIL t3_nostall: got gap %0d want 1", beat_at[2] - beat_at[1]); else n_pass++;
    end
    n_checks++; if (eop_at.size() != 1 || eop_at[0] != 13) $display("FAIL t3_eop: got %0d eops want 1 at 13", eop_at.size()); else n_pass++;
    n_checks++; if (!cap_done || cap_done_at != 14) $display("FAIL t3_done_at: got %0d want 14", cap_done_at); else n_pass++;
  endtask

  task automatic test_all_ch;
    logic [3:0]  es, ev, ee, eb, ed;
    logic [63:0] hdr_all;
    hdr_all = {16'h0003, 16'h0006, 16'h0009, 16'h000C};
    for (int ch = 0; ch < 4; ch++) cfg(ch, ch, 3 - ch, 0, 0, 0);
    start = 4'hF; tick; start = '0;
    for (int c = 0; c < 9; c++) begin
      es = (c == 0 || c == 3) ? 4'hF : 4'h0;
      ev = (c == 1 || c == 4) ? 4'hF : 4'h0;
      ee = (c == 2 || c == 5) ? 4'hF : 4'h0;
      eb = (c <= 5) ? 4'hF : 4'h0;
      ed = (c == 6) ? 4'hF : 4'h0;
      n_checks++; if (wr_sop !== es) $display("FAIL t4_sop c%0d: got %h want %h", c, wr_sop, es); else n_pass++;
      n_checks++; if (wr_vld !== ev) $display("FAIL t4_vld c%0d: got %h want %h", c, wr_vld, ev); else n_pass++;
      n_checks++; if (wr_eop !== ee) $display("FAIL t4_eop c%0d: got %h want %h", c, wr_eop, ee); else n_pass++;
      n_checks++; if (busy !== eb) $display("FAIL t4_busy c%0d: got %h want %h", c, busy, eb); else n_pass++;
      n_checks++; if (done !== ed) $display("FAIL t4_done c%0d: got %h want %h", c, done, ed); else n_pass++;
      if (c == 1 || c == 4) begin
        n_checks++; if (wr_data !== hdr_all) $display("FAIL t4_hdr c%0d: got %h want %h", c, wr_data, hdr_all); else n_pass++;
      end
      if (c == 6) begin
        n_checks++; if (pkt_cnt !== {4{16'd2}}) $display("FAIL t4_pkt_cnt: got %h want %h", pkt_cnt, {4{16'd2}}); else n_pass++;
      end
      stop = (c == 4) ? 4'hF : 4'h0;
      tick;
    end
    stop = '0;
  endtask

  task automatic test_cfg_update;
    logic [15:0] e;
    logic [15:0] exp_v [5];
    cfg(3, 0, 1, 2, 3, 2);
    start[3] = 1'b1; tick; start = '0;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_dest = 2'd0; cfg_prio = 2'd1;
    cfg_len = 8'd1; cfg_gap = 8'd3; cfg_num = 16'd2; start[3] = 1'b1;
    tick;
    cfg_we = 1'b0; start = '0;
    capture(3, 80, 0, 0);
    exp_v[0] = 16'h0024; exp_v[1] = exp_pay(3, 0, 0, 0); exp_v[2] = exp_pay(3, 0, 1, 1);
    exp_v[3] = 16'h0014; exp_v[4] = exp_pay(3, 1, 0, 2);
    n_checks++; if (!cap_done) $display("FAIL t5_done: run did not end within bound"); else n_pass++;
    n_checks++; if (sop_at.size() != 1) $display("FAIL t5_sops: got %0d want 1", sop_at.size()); else n_pass++;
    n_checks++;
    if (beat_v.size() != 5) $display("FAIL t5_beats: got %0d want 5", beat_v.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        e = exp_v[i];
        n_checks++; if (beat_v[i] !== e) $display("FAIL t5_beat%0d: got %h want %h", i, beat_v[i], e); else n_pass++;
      end
    end
    n_checks++; if (cap_cnt !== 16'd2) $display("FAIL t5_pkt_cnt: got %0d want 2", cap_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] e;
    cfg(2, 1, 1, 3, 0, 0);
    start[2] = 1'b1; tick; start = '0;
    repeat (9) tick;
    e = exp_pay(2, 1, 1, 4);
    n_checks++; if (wr_vld[2] !== 1'b1 || wr_data[47:32] !== e) $display("FAIL t6_pre: got vld %b data %h want 1 %h", wr_vld[2], wr_data[47:32], e); else n_pass++;
    rst_n = 1'b0;
    tick;
    n_checks++; if ({wr_sop, wr_vld, wr_eop} !== 12'h0) $display("FAIL t6_ctl: got %h want 000", {wr_sop, wr_vld, wr_eop}); else n_pass++;
    n_checks++; if (wr_data !== 64'h0) $display("FAIL t6_data: got %h want 0", wr_data); else n_pass++;
    n_checks++; if (busy !== 4'h0) $display("FAIL t6_busy: got %h want 0", busy); else n_pass++;
    n_checks++; if (pkt_cnt !== 64'h0) $display("FAIL t6_pkt_cnt: got %h want 0", pkt_cnt); else n_pass++;
    rst_n = 1'b1;
    tick;
    cfg(2, 1, 1, 2, 0, 1);
    start[2] = 1'b1; tick; start = '0;
    capture(2, 40, 0, 0);
    n_checks++;
    if (beat_v.size() != 3) $display("FAIL t6_beats: got %0d want 3", beat_v.size());
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        e = (i == 0) ? 16'h0025 : exp_pay(2, 0, i - 1, i - 1);
        n_checks++; if (beat_v[i] !== e) $display("FAIL t6_beat%0d: got %h want %h", i, beat_v[i], e); else n_pass++;
      end
    end
    n_checks++; if (cap_cnt !== 16'd1) $display("FAIL t6_pkt_cnt_restart: got %0d want 1", cap_cnt); else n_pass++;
  endtask

`ifdef HYDRA_GEN_LFSR_EN
  task automatic test_lfsr;
    cfg(0, 0, 0, 3, 0, 1);
    start[0] = 1'b1; tick; start = '0;
    capture(0, 40, 0, 0);
    n_checks++;
    if (beat_v.size() != 4) $display("FAIL t7_beats: got %0d want 4", beat_v.size());
    else begin
      n_pass++;
      n_checks++; if (beat_v[1] !== 16'h0001) $display("FAIL t7_pay0: got %h want 0001", beat_v[1]); else n_pass++;
      n_checks++; if (beat_v[2] !== 16'hB400) $display("FAIL t7_pay1: got %h want b400", beat_v[2]); else n_pass++;
      n_checks++; if (beat_v[3] !== 16'h5A00) $display("FAIL t7_pay2: got %h want 5a00", beat_v[3]); else n_pass++;
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_gap;
    test_pause;
    test_all_ch;
    test_cfg_update;
    test_reset_mid;
`ifdef HYDRA_GEN_LFSR_EN
    test_lfsr;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
